truth_table_scanner: RTL
========================

Name: truth_table_scanner

Overview:
- Sequential counterpart to the combinational sum-of-products evaluators. It drives every input pattern into an external combinational function, samples the output, and builds the truth table.
- It then streams the minterm indices out over a valid/ready handshake, which recovers the canonical SoP from a circuit.
- It sits between a function-under-test and a display or checker block.

Parameters:
- N_VARS, 3, number of function inputs; the table has 2**N_VARS entries.
- SETTLE, 1, extra cycles each pattern is held before sampling (range 0..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a scan; ignored while busy=1
- var_out  output  N_VARS  pattern driven to the function; MSB = first variable (x)
- f_in  input  1  function output for the current var_out
- busy  output  1  high from the cycle after start is accepted until done
- table_out  output  2**N_VARS  bit i = f at pattern i; stable from done until the next accepted start
- minterm_idx  output  N_VARS  current minterm index
- minterm_valid  output  1  minterm_idx is valid
- minterm_ready  input  1  consumer accepts the minterm
- minterm_last  output  1  qualifies the highest-index minterm
- minterm_count  output  N_VARS+1  number of 1 entries; valid when done=1
- done  output  1  one-cycle pulse at the end of a scan

Behaviour:
- Reset (asynchronous, rst_n=0): the FSM goes to IDLE. The following outputs are 0: var_out, busy, table_out, minterm_idx, minterm_valid, minterm_last, minterm_count, done. Reset mid-scan or mid-emit aborts immediately, with no partial done.
- FSM states: IDLE, DRIVE, EMIT, DONE.
- IDLE:
  - start=1 clears table_out, minterm_count, pattern index p and settle counter.
  - It sets var_out=0 and busy=1, then moves to DRIVE.
- DRIVE:
  - var_out=p is held for exactly SETTLE+1 cycles.
  - On the clock edge ending the last of those cycles: table_out[p] <= f_in, and minterm_count increments if f_in=1.
  - If p == 2**N_VARS-1, move to EMIT with scan pointer q=0. Otherwise p increments and var_out updates on the same edge.
  - The full scan takes 2**N_VARS*(SETTLE+1) cycles.
- EMIT:
  - If table_out[q]=0, advance q by one per cycle with minterm_valid=0.
  - If table_out[q]=1, drive minterm_valid=1 and minterm_idx=q. minterm_last=1 if no set bit exists above q.
  - minterm_idx and minterm_last stay stable until minterm_valid && minterm_ready. Transfer happens on that edge, and q then advances.
  - Once q passes 2**N_VARS-1 (with the last transfer done, or no ones at all), move to DONE.
  - minterm_ready asserted while minterm_valid=0 has no effect.
  - minterm_valid never drops without a transfer, except on reset.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- var_out holds the last pattern after the scan, until the next start.
- start during busy or DONE is ignored, not queued.
- Boundary cases:
  - All-zero function: no valid is ever raised. The FSM walks q and reaches done with minterm_count=0.
  - All-one function: 2**N_VARS transfers; minterm_last is asserted with index 2**N_VARS-1.
  - Back-to-back minterms with ready held high: one transfer per cycle.
- minterm_count width: N_VARS+1 bits, so the all-one case (2**N_VARS) does not wrap.

Decomposition:
- A shared package holds:
  - the FSM state encoding localparams (IDLE, DRIVE, EMIT, DONE);
  - the TABLE_SIZE = 2**N_VARS helper function;
  - the SETTLE counter width constant.
- One natural sub-module is tts_minterm_emitter. It holds the EMIT logic: the pointer, the skip-zeros walk, the handshake and the last-flag lookahead. Its inputs are table_out and a go pulse; it returns a finished pulse.
- Pattern drive, sampling and the top FSM stay in truth_table_scanner.

Test Plan:
- f = x'yz + xy'z' + xyz, N_VARS=3, SETTLE=1, ready tied 1, start pulse → done 16 cycles after the scan starts plus the emit cycles. Required: table_out=8'h98; minterms 3,4,7 in order; last only on 7; minterm_count=3.
- f=0 (constant) → no minterm_valid; table_out=8'h00; minterm_count=0; single done pulse.
- f=1 (constant), ready tied 1 → indices 0..7 on consecutive cycles; last on 7; minterm_count=4'd8; table_out=8'hFF.
- Same f as the first scenario with ready low for 5 cycles at each valid → minterm_idx and minterm_last held stable throughout. Sequence still 3,4,7, no duplicates or drops.
- start re-pulsed during DRIVE, and again in the DONE cycle → ignored: exactly one done and table_out=8'h98. A subsequent start from IDLE rescans and clears table_out first.
- rst_n asserted low for one cycle while minterm_valid=1 with idx=4 → outputs are 0 immediately (asynchronous); no done. A new start produces a full correct scan.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// +------------------------------------------------------------------+
// | truth_table_scanner_pkg: shared FSM encoding and sizing helpers  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package truth_table_scanner_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Settle counter covers SETTLE values 0..15.
  localparam int SETTLE_W = 4;

  function automatic int table_size(input int n_vars);
    return 1 << n_vars;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tts_minterm_emitter.sv
// +------------------------------------------------------------------+
// | tts_minterm_emitter: walks the truth table and streams set bits  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tts_minterm_emitter
  import truth_table_scanner_pkg::*;
#(
  parameter int N_VARS = 3,
  localparam int TS = table_size(N_VARS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [TS-1:0]     table_in,
  input  logic              minterm_ready,
  output logic [N_VARS-1:0] minterm_idx,
  output logic              minterm_valid,
  output logic              minterm_last,
  output logic              finished
);

  logic              r_active;
  logic [N_VARS-1:0] r_q;
  logic              w_bit;
  logic              w_advance;
  logic [TS-1:0]     w_upper;

  assign w_bit         = table_in[r_q];
  assign minterm_valid = r_active & w_bit;
  assign minterm_idx   = r_q;

  // Last flag: nothing set strictly above the current pointer.
  assign w_upper      = (table_in >> r_q) >> 1;
  assign minterm_last = minterm_valid & (w_upper == '0);

  // Zeros are skipped one per cycle; ones wait for the handshake.
  assign w_advance = r_active & (~w_bit | minterm_ready);
  assign finished  = w_advance & (&r_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_q      <= '0;
    end else if (go) begin
      r_active <= 1'b1;
      r_q      <= '0;
    end else if (w_advance) begin
      if (&r_q) begin
        r_active <= 1'b0;
      end else begin
        r_q <= r_q + N_VARS'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// +------------------------------------------------------------------+
// | truth_table_scanner: sweeps all input patterns, captures the     |
// | truth table and streams the minterm indices. Revision: 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1,
  localparam int TS = table_size(N_VARS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_VARS-1:0] var_out,
  input  logic              f_in,
  output logic              busy,
  output logic [TS-1:0]     table_out,
  output logic [N_VARS-1:0] minterm_idx,
  output logic              minterm_valid,
  input  logic              minterm_ready,
  output logic              minterm_last,
  output logic [N_VARS:0]   minterm_count,
  output logic              done
);

  localparam logic [SETTLE_W-1:0] C_SETTLE = SETTLE_W'(SETTLE);
  localparam logic [N_VARS-1:0]   C_LAST_P = N_VARS'(TS - 1);

  logic [1:0]          r_state;
  logic [N_VARS-1:0]   r_p;
  logic [SETTLE_W-1:0] r_settle;
  logic [TS-1:0]       r_table;
  logic [N_VARS:0]     r_count;
  logic                w_sample;
  logic                w_go;
  logic                w_finished;

  // Each pattern is sampled on the edge closing its SETTLE+1 hold window.
  assign w_sample = (r_state == ST_DRIVE) && (r_settle == C_SETTLE);
  assign w_go     = w_sample && (r_p == C_LAST_P);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_p      <= '0;
      r_settle <= '0;
      r_table  <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_table  <= '0;
            r_count  <= '0;
            r_p      <= '0;
            r_settle <= '0;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_sample) begin
            r_table[r_p] <= f_in;
            r_count      <= r_count + (N_VARS + 1)'(f_in);
            r_settle     <= '0;
            if (r_p == C_LAST_P) begin
              r_state <= ST_EMIT;
            end else begin
              r_p <= r_p + N_VARS'(1);
            end
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        ST_EMIT: begin
          if (w_finished) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  tts_minterm_emitter #(
    .N_VARS (N_VARS)
  ) u_emitter (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (w_go),
    .table_in      (r_table),
    .minterm_ready (minterm_ready),
    .minterm_idx   (minterm_idx),
    .minterm_valid (minterm_valid),
    .minterm_last  (minterm_last),
    .finished      (w_finished)
  );

  assign var_out       = r_p;
  assign table_out     = r_table;
  assign minterm_count = r_count;
  assign busy          = (r_state == ST_DRIVE) || (r_state == ST_EMIT);
  assign done          = (r_state == ST_DONE);

endmodule

`default_nettype wire
